uart_rx: RTL

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_pkg.sv | 17 +
 rtl/uart_sync.sv | 28 ++
 rtl/uart_rx.sv | 133 +++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states and baud arithmetic.
// Also reused by the transmitter.
package uart_pkg;

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } rx_state_t;

   function automatic int cycles_per_bit(input int clock_freq,
                                         input int baud_rate);
      return (clock_freq + baud_rate / 2) / baud_rate;
   endfunction

endpackage

// File: rtl/uart_sync.sv
// Multi-stage flop synchronizer for an asynchronous single-bit input.
// Flops come out of reset at a chosen idle level.
module uart_sync #(
   parameter int   STAGES      = 2,
   parameter logic RESET_VALUE = 1'b1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] ff;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ff <= {STAGES{RESET_VALUE}};
      end else begin
         ff[0] <= d;
         for (int i = 1; i < STAGES; i++) begin
            ff[i] <= ff[i-1];
         end
      end
   end

   assign q = ff[STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// UART receiver: mid-bit sampling, stop-bit check, one-deep output
// register with valid/ready handoff and overrun/frame-error pulses.
module uart_rx
   import uart_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int BAUD_RATE  = 9600,
   parameter int CLOCK_FREQ = 50_000_000,
   parameter int STOP_BITS  = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  rx,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  valid,
   input  logic                  ready,
   output logic                  frame_error,
   output logic                  overrun
);

   localparam int CYCLES_PER_BIT = cycles_per_bit(CLOCK_FREQ, BAUD_RATE);
   localparam int HALF_BIT       = CYCLES_PER_BIT / 2;
   localparam int CW             = $clog2(CYCLES_PER_BIT) + 1;
   localparam int BW             = $clog2(DATA_WIDTH) + 1;

   localparam logic [CW-1:0] HALF_LAST = CW'(HALF_BIT - 1);
   localparam logic [CW-1:0] BIT_LAST  = CW'(CYCLES_PER_BIT - 1);
   localparam logic [BW-1:0] DATA_LAST = BW'(DATA_WIDTH - 1);
   localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

   logic                  line;
   rx_state_t             state;
   logic [CW-1:0]         cnt;
   logic [BW-1:0]         bit_cnt;
   logic [DATA_WIDTH-1:0] shift;
   logic                  stop_bad;
   logic                  done;

   uart_sync #(
      .STAGES      (2),
      .RESET_VALUE (1'b1)
   ) u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (rx),
      .q     (line)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         cnt         <= '0;
         bit_cnt     <= '0;
         shift       <= '0;
         stop_bad    <= 1'b0;
         done        <= 1'b0;
         data_out    <= '0;
         valid       <= 1'b0;
         frame_error <= 1'b0;
         overrun     <= 1'b0;
      end else begin
         frame_error <= 1'b0;
         overrun     <= 1'b0;
         done        <= 1'b0;

         // A finished frame lands one cycle after its last stop sample.
         if (done) begin
            if (!valid || ready) begin
               data_out <= shift;
               valid    <= 1'b1;
            end else begin
               overrun <= 1'b1;
            end
         end else if (valid && ready) begin
            valid <= 1'b0;
         end

         unique case (state)
            IDLE: begin
               cnt      <= '0;
               bit_cnt  <= '0;
               stop_bad <= 1'b0;
               if (!line) begin
                  state <= START;
               end
            end
            START: begin
               if (cnt == HALF_LAST) begin
                  cnt   <= '0;
                  state <= line ? IDLE : DATA;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            DATA: begin
               if (cnt == BIT_LAST) begin
                  cnt   <= '0;
                  shift <= {line, shift[DATA_WIDTH-1:1]};
                  if (bit_cnt == DATA_LAST) begin
                     bit_cnt <= '0;
                     state   <= STOP;
                  end else begin
                     bit_cnt <= bit_cnt + BW'(1);
                  end
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            STOP: begin
               if (cnt == BIT_LAST) begin
                  cnt <= '0;
                  if (bit_cnt == STOP_LAST) begin
                     bit_cnt <= '0;
                     state   <= IDLE;
                     if (stop_bad || !line) begin
                        frame_error <= 1'b1;
                     end else begin
                        done <= 1'b1;
                     end
                  end else begin
                     bit_cnt  <= bit_cnt + BW'(1);
                     stop_bad <= stop_bad | ~line;
                  end
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
